coherent_bus_arbiter: RTL
=========================

# coherent_bus_arbiter

Parametrised, transaction-holding arbiter for the shared coherence bus between the private caches and memory. It grants one requester at a time and holds that grant until the owner signals `done` or a hold timeout expires. It then drains until every snooper and the memory side report not-busy before arbitrating again. Selectable round-robin or fixed-priority-with-aging policy. Sits between the per-CPU cache controllers and the bus mux/snoop broadcast logic.

## Interface
Parameters:
- `NUM_REQ`, 4 — number of requesters (≥2).
- `MODE`, 0 — 0: round-robin; 1: fixed priority (index 0 highest) with starvation aging.
- `MAX_HOLD`, 16 — maximum cycles a grant may be held; 0 disables the timeout.
- `STARVE_LIMIT`, 8 — MODE 1 only: wait cycles before a requester is promoted (≥1).

Ports:
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `req` in NUM_REQ — per-requester bus request (level).
- `done` in 1 — current owner finished its bus transaction (1-cycle pulse).
- `busy` in NUM_REQ+1 — per-cache transient/snoop busy, plus memory busy at MSB.
- `gnt` out NUM_REQ — one-hot registered grant, held for the whole transaction.
- `gnt_valid` out 1 — `|gnt`.
- `gnt_id` out $clog2(NUM_REQ) — index of the current owner; holds its last value when `gnt_valid`=0.
- `timeout` out 1 — 1-cycle pulse when a grant is revoked by MAX_HOLD.

## Operation
- FSM states:
  - IDLE — no owner.
  - OWNED — `gnt` held.
  - DRAIN — `gnt` low, waiting for the bus to quiesce.
- IDLE / DRAIN arbitration:
  - Arbitrate only when `|busy`==0.
  - If `|req` is set, register the winner into `gnt`/`gnt_id` and go to OWNED.
  - If `|busy`=1 or no requests, no grant is issued and the state is unchanged.
  - DRAIN with `|busy`==0 behaves exactly as IDLE; with no requests it goes to IDLE.
- OWNED:
  - Hold counter increments each cycle.
  - `done`=1, or the owner's `req` deasserts → go to DRAIN, `gnt` cleared.
  - Otherwise, if MAX_HOLD≠0 and the counter reaches MAX_HOLD−1 → go to DRAIN, `gnt` cleared, `timeout` pulses in the same registered cycle as `gnt` falls.
  - `done` on the terminal count wins: no `timeout`.
  - `busy` is ignored while OWNED (the owner's own snoops are expected).
- `done` outside OWNED is ignored.
- MODE 0 (round-robin):
  - Search `req` starting at `ptr`, wrapping mod NUM_REQ.
  - On grant to index i: `ptr` ← (i+1) mod NUM_REQ. At i=NUM_REQ−1, `ptr` wraps to 0.
- MODE 1 (fixed priority with aging):
  - Per-requester wait counter. It increments (saturating at STARVE_LIMIT) each cycle that `req[k]`=1 and `gnt[k]`=0, and clears to 0 when k is granted or `req[k]`=0.
  - Requesters whose counter equals STARVE_LIMIT are "promoted".
  - If any requester is promoted, the lowest-index promoted requester wins; else the lowest-index requester wins.
- Hold counter width is $clog2(MAX_HOLD+1); it clears on entry to OWNED.
- Invariants (bench assertions):
  - `gnt` is one-hot or zero.
  - No rising edge of `gnt` while `|busy`=1 in the prior cycle.

## Timing
- Reset values:
  - Outputs: `gnt`=0, `gnt_valid`=0, `gnt_id`=0, `timeout`=0.
  - Internal: state=IDLE, `ptr`=0, hold counter=0, all wait counters=0.
- Reset mid-transaction: `gnt` is low the cycle after `rst` is sampled; no `timeout` pulse.
- Grant latency: `req` sampled in IDLE with `|busy`=0 at cycle t → `gnt` high at t+1.
- Release: `done` at cycle t → `gnt` low at t+1 (DRAIN).
- Back-to-back: if `|busy`=0 at t+1, the next grant is at t+2. The minimum bus gap is one cycle with `gnt`=0.
- Timeout: grant rises at cycle g, no `done` → `gnt` low and `timeout`=1 at g+MAX_HOLD. The owner held the bus for exactly MAX_HOLD cycles.
- Simultaneous `req` changes and `busy` rising in the arbitration cycle: `busy` has priority, no grant.

## Test plan
- Reset, then `req`=4'b1111 with `done` one cycle after each grant, MODE 0 → grants in order 0,1,2,3,0; one-cycle gap between grants; `ptr` wraps after 3.
- `req`=4'b0101 and `busy[4]`=1 for 5 cycles, then cleared → no `gnt` during those 5 cycles; `gnt`=4'b0001 one cycle after `busy` clears.
- MAX_HOLD=4, grant to requester 2, no `done` → `gnt` held 4 cycles, then `gnt`=0 with `timeout`=1 for one cycle; `done` on cycle 4 instead → no `timeout`.
- MODE 1, STARVE_LIMIT=3, `req[0]` and `req[3]` held, each `done` after 1 cycle → requester 0 wins repeatedly until requester 3's counter reaches 3, then requester 3 is granted and its counter clears.
- `rst` asserted while OWNED with requester 1 → `gnt`=0 and `gnt_id`=0 the next cycle; after release, `req`=4'b0011 grants requester 0 first.
- Owner drops `req` without `done` → treated as release: `gnt` low next cycle, no `timeout`.

Source files
------------

// File: rtl/coherent_bus_arbiter.sv
// coherent_bus_arbiter
//   Transaction-holding arbiter for the shared coherence bus. One requester
//   owns the bus until it pulses done, drops its request, or the MAX_HOLD
//   timeout expires. The arbiter then drains until every snooper and the
//   memory side report idle before it issues another grant.
//   MODE 0 : round-robin starting at a rotating pointer.
//   MODE 1 : fixed priority (index 0 highest) with starvation aging.
// Ports
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   req       : per-requester bus request (level)
//   done      : owner finished its transaction (1-cycle pulse)
//   busy      : per-cache snoop busy, memory busy at MSB
//   gnt       : registered one-hot grant
//   gnt_valid : |gnt
//   gnt_id    : index of the current/last owner
//   timeout   : 1-cycle pulse when a grant is revoked by MAX_HOLD
module coherent_bus_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MODE         = 0,
  parameter int MAX_HOLD     = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       done,
  input  logic [NUM_REQ:0]           busy,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       gnt_valid,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       timeout
);

  localparam int unsigned N   = NUM_REQ;
  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int unsigned WCW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [HCW-1:0]   hold_q, hold_d;
  logic             timeout_q, timeout_d;
  logic [WCW-1:0]   wait_q [N];
  logic [WCW-1:0]   wait_d [N];

  logic             win_found;
  logic [IDW-1:0]   win_idx;
  logic [IDW-1:0]   rr_idx;

  function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base,
                                              input int unsigned    off);
    return IDW'((32'(base) + off) % N);
  endfunction

  // Winner selection; only consumed when the FSM is allowed to arbitrate.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_idx    = '0;
    if (MODE == 0) begin
      for (int unsigned k = 0; k < N; k++) begin
        rr_idx = rr_index(ptr_q, k);
        if (!win_found && req[rr_idx]) begin
          win_found = 1'b1;
          win_idx   = rr_idx;
        end
      end
    end else begin
      // Promoted (starved) requesters beat plain priority order.
      for (int unsigned k = 0; k < N; k++) begin
        if (!win_found && req[k] && (wait_q[k] == WCW'(STARVE_LIMIT))) begin
          win_found = 1'b1;
          win_idx   = IDW'(k);
        end
      end
      for (int unsigned k = 0; k < N; k++) begin
        if (!win_found && req[k]) begin
          win_found = 1'b1;
          win_idx   = IDW'(k);
        end
      end
    end
  end

  // Starvation counters: count waiting cycles, saturate, clear on ownership
  // or when the request goes away.
  always_comb begin
    for (int unsigned k = 0; k < N; k++) begin
      wait_d[k] = wait_q[k];
      if (!req[k] || gnt_q[k]) begin
        wait_d[k] = '0;
      end else if (wait_q[k] != WCW'(STARVE_LIMIT)) begin
        wait_d[k] = wait_q[k] + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE, DRAIN: begin
        gnt_d = '0;
        // Any busy source blocks arbitration, even if requests changed.
        if (!(|busy)) begin
          if (|req) begin
            gnt_d          = '0;
            gnt_d[win_idx] = 1'b1;
            id_d           = win_idx;
            hold_d         = '0;
            state_d        = OWNED;
            ptr_d          = (win_idx == IDW'(N - 1)) ? '0 : win_idx + 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      OWNED: begin
        hold_d = hold_q + 1'b1;
        // A release on the terminal count takes precedence over the timeout.
        if (done || !(|(req & gnt_q))) begin
          state_d = DRAIN;
          gnt_d   = '0;
        end else if ((MAX_HOLD != 0) && (hold_q == HCW'(MAX_HOLD - 1))) begin
          state_d   = DRAIN;
          gnt_d     = '0;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      id_q      <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
        wait_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
      for (int unsigned k = 0; k < N; k++) begin
        wait_q[k] <= wait_d[k];
      end
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;
  assign gnt_id    = id_q;
  assign timeout   = timeout_q;

endmodule
